// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// Combinational wires only; the fetch side drives req/addr, memory drives ready/rdata.
// Memory may hold imem_ready low for any number of cycles; the fetch side keeps addr stable.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single outstanding imem request, IF/ID register.
// Latency: zero-wait memory puts an instruction requested in cycle N into IF/ID at N+1.
// Backpressure: a stall parks one returned word in a skid buffer and stops requesting.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_write,
  input  logic                if_id_write,
  input  logic                branch_taken,
  input  logic [31:0]         branch_target,
  fetch_unit_if.master        imem,
  output logic                if_id_valid,
  output logic [31:0]         if_id_pc,
  output logic [31:0]         if_id_pc_plus4,
  output logic [31:0]         if_id_instr
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic [31:0] hold_instr, hold_nxt;
  logic        id_load;
  logic        id_bubble;
  logic [31:0] id_instr_src;
  logic [31:0] pc_plus4;
  logic        advance;

  assign advance  = pc_write && if_id_write;
  assign pc_plus4 = pc + 32'd4;

  // DRAIN re-presents the stale address so the pending handshake stays stable.
  assign imem.imem_req  = !rst && (state != HOLD);
  assign imem.imem_addr = (state == DRAIN) ? req_addr : pc;

  // Next-state, next-PC and IF/ID load/bubble decisions.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    hold_nxt     = hold_instr;
    id_load      = 1'b0;
    id_bubble    = 1'b0;
    id_instr_src = hold_instr;
    case (state)
      FETCH: begin
        // pc cannot move while a request waits, so re-latching it is harmless.
        req_addr_nxt = pc;
        if (imem.imem_ready) begin
          if (branch_taken) begin
            pc_nxt    = branch_target;
            id_bubble = 1'b1;
          end else if (advance) begin
            id_load      = 1'b1;
            id_instr_src = imem.imem_rdata;
            pc_nxt       = pc_plus4;
          end else begin
            hold_nxt  = imem.imem_rdata;
            state_nxt = HOLD;
          end
        end else if (branch_taken) begin
          pc_nxt    = branch_target;
          id_bubble = 1'b1;
          state_nxt = DRAIN;
        end else if (if_id_write) begin
          id_bubble = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_nxt    = branch_target;
          id_bubble = 1'b1;
          state_nxt = FETCH;
        end else if (advance) begin
          id_load   = 1'b1;
          pc_nxt    = pc_plus4;
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        if (branch_taken) begin
          pc_nxt    = branch_target;
          id_bubble = 1'b1;
        end else if (if_id_write) begin
          id_bubble = 1'b1;
        end
        if (imem.imem_ready) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // PC, outstanding address, skid buffer and IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC;
      req_addr       <= RESET_PC;
      hold_instr     <= NOP_INSTR;
      if_id_valid    <= 1'b0;
      if_id_pc       <= 32'd0;
      if_id_pc_plus4 <= 32'd0;
      if_id_instr    <= NOP_INSTR;
    end else begin
      pc         <= pc_nxt;
      req_addr   <= req_addr_nxt;
      hold_instr <= hold_nxt;
      if (id_load) begin
        if_id_valid    <= 1'b1;
        if_id_pc       <= pc;
        if_id_pc_plus4 <= pc_plus4;
        if_id_instr    <= id_instr_src;
      end else if (id_bubble) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transaction-level reference model.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write = 1'b1;
  logic        if_id_write = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        rdy = 1'b0;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr;

  int tests = 0;
  int fails = 0;
  int bad_20 = 0;
  int bad_300 = 0;
  int bad_buf = 0;

  fetch_unit_if bus();
  assign bus.imem_ready = rdy;
  assign bus.imem_rdata = bus.imem_addr ^ KEY;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem           (bus.master),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_instr    (if_id_instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: next fetch PC, an optional parked word, an optional
  // abandoned request that must still be handshaken, and the IF/ID contents.
  bit          m_init = 0;
  logic [31:0] m_pc;
  bit          m_parked;
  logic [31:0] m_parked_word;
  bit          m_abandoned;
  logic [31:0] m_abandoned_addr;
  bit          m_v;
  logic [31:0] m_ipc, m_ipc4, m_instr;

  function automatic logic [31:0] m_addr();
    return m_abandoned ? m_abandoned_addr : m_pc;
  endfunction

  task automatic m_bubble();
    m_v = 0;
    m_instr = NOP;
  endtask

  task automatic m_deliver(input logic [31:0] word);
    m_v = 1;
    m_ipc = m_pc;
    m_ipc4 = m_pc + 32'd4;
    m_instr = word;
    m_pc = m_pc + 32'd4;
  endtask

  always @(posedge clk) begin
    bit go;
    logic [31:0] word;
    go = pc_write && if_id_write;
    word = m_addr() ^ KEY;
    if (rst) begin
      m_init = 1;
      m_pc = 32'd0;
      m_parked = 0;
      m_abandoned = 0;
      m_v = 0; m_ipc = 0; m_ipc4 = 0; m_instr = NOP;
    end else if (m_init) begin
      if (m_parked) begin
        if (branch_taken) begin
          m_parked = 0; m_pc = branch_target; m_bubble();
        end else if (go) begin
          m_parked = 0; m_deliver(m_parked_word);
        end
      end else if (m_abandoned) begin
        if (branch_taken) begin
          m_pc = branch_target; m_bubble();
        end else if (if_id_write) begin
          m_bubble();
        end
        if (rdy) m_abandoned = 0;
      end else if (rdy) begin
        if (branch_taken) begin
          m_pc = branch_target; m_bubble();
        end else if (go) begin
          m_deliver(word);
        end else begin
          m_parked = 1; m_parked_word = word;
        end
      end else begin
        if (branch_taken) begin
          m_abandoned = 1; m_abandoned_addr = m_pc;
          m_pc = branch_target; m_bubble();
        end else if (if_id_write) begin
          m_bubble();
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("imem_req", {31'd0, bus.imem_req}, {31'd0, !rst && !m_parked});
      if (!rst && !m_parked) chk("imem_addr", bus.imem_addr, m_addr());
      chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_v});
      chk("if_id_instr", if_id_instr, m_instr);
      chk("if_id_pc", if_id_pc, m_ipc);
      chk("if_id_pc_plus4", if_id_pc_plus4, m_ipc4);
      if (if_id_valid && if_id_pc == 32'h20) bad_20++;
      if (bus.imem_req && bus.imem_addr == 32'h300) bad_300++;
      if (if_id_instr == (32'h404 ^ KEY) && bad_buf >= 0 && if_id_pc == 32'h0) bad_buf++;
    end
  end

  task automatic cyc(input logic r, input logic pw, input logic iw, input logic br,
                     input logic [31:0] tgt, input logic rd);
    rst = r; pc_write = pw; if_id_write = iw;
    branch_taken = br; branch_target = tgt; rdy = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset for two cycles.
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_pc", if_id_pc, 32'd0);
    // Zero-wait streaming.
    cyc(0, 1, 1, 0, 0, 1);
    chk("zw_pc0", if_id_pc, 32'h0);
    chk("zw_instr0", if_id_instr, 32'hA5A5_0000);
    chk("zw_valid0", {31'd0, if_id_valid}, 32'd1);
    chk("zw_pc4_0", if_id_pc_plus4, 32'h4);
    cyc(0, 1, 1, 0, 0, 1);
    chk("zw_pc1", if_id_pc, 32'h4);
    chk("zw_addr2", bus.imem_addr, 32'h8);
    // Load-use stall while PC=8 returns.
    cyc(0, 0, 0, 0, 0, 1);
    chk("stall_pc", if_id_pc, 32'h4);
    chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
    cyc(0, 1, 1, 0, 0, 1);
    chk("unstall_pc", if_id_pc, 32'h8);
    chk("unstall_instr", if_id_instr, 32'hA5A5_0008);
    cyc(0, 1, 1, 0, 0, 1);
    chk("after_stall_pc", if_id_pc, 32'hC);
    // Branch flush with if_id_write=0.
    cyc(0, 1, 0, 1, 32'h100, 1);
    chk("flush_valid", {31'd0, if_id_valid}, 32'd0);
    chk("flush_instr", if_id_instr, NOP);
    chk("flush_addr", bus.imem_addr, 32'h100);
    chk("flush_pc_hold", if_id_pc, 32'hC);
    cyc(0, 1, 1, 0, 0, 1);
    chk("tgt_pc", if_id_pc, 32'h100);
    chk("tgt_instr", if_id_instr, 32'hA5A5_0100);
    // Redirect during a slow response on 0x20.
    cyc(0, 1, 1, 1, 32'h20, 1);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 32'h200, 0);
    chk("drain_addr", bus.imem_addr, 32'h20);
    cyc(0, 1, 1, 0, 0, 0);
    chk("drain_addr2", bus.imem_addr, 32'h20);
    cyc(0, 1, 1, 0, 0, 1);
    chk("post_drain_addr", bus.imem_addr, 32'h200);
    chk("post_drain_valid", {31'd0, if_id_valid}, 32'd0);
    cyc(0, 1, 1, 0, 0, 1);
    chk("redir_pc", if_id_pc, 32'h200);
    // Back-to-back redirects while draining.
    cyc(0, 1, 1, 1, 32'h300, 0);
    cyc(0, 1, 1, 1, 32'h400, 0);
    chk("b2b_stale_addr", bus.imem_addr, 32'h204);
    cyc(0, 1, 1, 0, 0, 1);
    chk("b2b_addr", bus.imem_addr, 32'h400);
    cyc(0, 1, 1, 0, 0, 1);
    chk("b2b_pc", if_id_pc, 32'h400);
    // Reset while holding a parked word.
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 1, 1, 0, 0, 1);
    chk("hrst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("hrst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("hrst_instr", if_id_instr, NOP);
    chk("hrst_pc4", if_id_pc_plus4, 32'd0);
    chk("hrst_addr", bus.imem_addr, 32'h0);
    cyc(0, 1, 1, 0, 0, 1);
    chk("hrst_first_instr", if_id_instr, 32'hA5A5_0000);
    // PC wrap at the top of the address space.
    cyc(0, 1, 1, 1, 32'hFFFF_FFFC, 1);
    cyc(0, 1, 1, 0, 0, 1);
    chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_id_pc_plus4, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    // Redirect out of HOLD, then stalls and bubbles without a response.
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 1, 1, 32'h500, 1);
    chk("hold_br_valid", {31'd0, if_id_valid}, 32'd0);
    cyc(0, 1, 1, 0, 0, 1);
    chk("hold_br_pc", if_id_pc, 32'h500);
    cyc(0, 1, 0, 0, 0, 0);
    chk("wait_hold_valid", {31'd0, if_id_valid}, 32'd1);
    cyc(0, 1, 1, 0, 0, 0);
    chk("wait_bubble_valid", {31'd0, if_id_valid}, 32'd0);
    cyc(0, 1, 1, 0, 0, 1);
    chk("wait_done_pc", if_id_pc, 32'h504);
    // Words that must never surface.
    chk("never_20", bad_20, 32'd0);
    chk("never_300", bad_300, 32'd0);
    chk("never_parked", bad_buf, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
